uart_tx_arbiter: RTL and testbench

- Shares the single SoC UART transmitter (uart_txd path) between NREQ byte-stream requesters, e.g. CPU console and debug/bootloader channel.
- Grants the transmitter to one requester for a whole packet. Packets are delimited by req_last.
- Rotates priority round-robin between packets.
- Reclaims a stalled grant after an idle timeout, so a hung requester cannot block the console.

---
 rtl/uart_arb_pkg.sv | 16 +
 rtl/rr_priority_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 102 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmitter arbiter and its priority picker.
package uart_arb_pkg;

   localparam int UART_BYTE_W = 8;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Bits needed to hold an idle count running from 0 up to timeout-1.
   function automatic int idle_cnt_w(input int timeout);
      return (timeout > 2) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: returns the first set request at or above ptr, wrapping modulo N.
module rr_priority_pick #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] index
);

   int               sum;
   logic [IDX_W-1:0] cand;

   // Walk from the farthest offset down so the nearest request to ptr wins last.
   always_comb begin
      found = 1'b0;
      index = '0;
      sum   = 0;
      cand  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         sum = int'(ptr) + k;
         if (sum >= N) begin
            sum = sum - N;
         end
         cand = IDX_W'(sum);
         if (req[cand]) begin
            found = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NREQ byte-stream requesters, one whole packet per grant,
// with round-robin rotation between packets and forced release of a stalled grant.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 1024,
   parameter int ID_W    = $clog2(NREQ)
) (
   input  logic                        sys_clk,
   input  logic                        sys_resetn,
   input  logic [NREQ-1:0]             req_valid,
   input  logic [NREQ*UART_BYTE_W-1:0] req_data,
   input  logic [NREQ-1:0]             req_last,
   output logic [NREQ-1:0]             req_ready,
   output logic                        tx_valid,
   output logic [UART_BYTE_W-1:0]      tx_data,
   input  logic                        tx_ready,
   output logic                        busy,
   output logic [ID_W-1:0]             grant_id,
   output logic                        timeout_evt
);

   localparam int              CNT_W      = idle_cnt_w(TIMEOUT);
   localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT - 1);

   arb_state_e       state;
   logic [ID_W-1:0]  rr_ptr;
   logic [CNT_W-1:0] idle_cnt;
   logic             pick_found;
   logic [ID_W-1:0]  pick_idx;
   logic             g_valid;
   logic             g_last;
   logic             handshake;
   logic [ID_W-1:0]  next_ptr;

   rr_priority_pick #(
      .N     (NREQ),
      .IDX_W (ID_W)
   ) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .found (pick_found),
      .index (pick_idx)
   );

   assign g_valid   = req_valid[grant_id];
   assign g_last    = req_last[grant_id];
   assign handshake = (state == LOCKED) && g_valid && tx_ready;
   assign next_ptr  = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + ID_W'(1);
   assign busy      = (state == LOCKED);

   // The grantee is wired straight through so tx_valid/tx_data inherit its stability under backpressure.
   always_comb begin
      tx_valid  = 1'b0;
      tx_data   = '0;
      req_ready = '0;
      if (state == LOCKED) begin
         tx_valid            = g_valid;
         tx_data             = req_data[grant_id*UART_BYTE_W +: UART_BYTE_W];
         req_ready[grant_id] = tx_ready;
      end
   end

   // Any offered byte, even one stalled by tx_ready, resets the idle count, so only silence times out.
   always_ff @(posedge sys_clk or negedge sys_resetn) begin
      if (!sys_resetn) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         idle_cnt    <= '0;
         timeout_evt <= 1'b0;
      end else begin
         timeout_evt <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_id <= pick_idx;
                  idle_cnt <= '0;
                  state    <= LOCKED;
               end
            end
            LOCKED: begin
               if (handshake && g_last) begin
                  state  <= IDLE;
                  rr_ptr <= next_ptr;
               end else if (g_valid) begin
                  idle_cnt <= '0;
               end else if (idle_cnt == IDLE_LIMIT) begin
                  state       <= IDLE;
                  rr_ptr      <= next_ptr;
                  timeout_evt <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: packet-level requester sources, a rule-based reference
// model compared every cycle, and directed scenarios pinned with hand-computed byte orders and latencies.
module tb_uart_tx_arbiter;

   localparam int NREQ    = 2;
   localparam int TIMEOUT = 4;
   localparam int ID_W    = 1;

   logic              sys_clk = 1'b0;
   logic              sys_resetn;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*8-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic              tx_valid;
   logic [7:0]        tx_data;
   logic              tx_ready;
   logic              busy;
   logic [ID_W-1:0]   grant_id;
   logic              timeout_evt;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic checkEn = 1'b0;

   logic [8:0]      srcQ0[$];
   logic [8:0]      srcQ1[$];
   logic [NREQ-1:0] hsAtNeg = '0;
   logic [7:0]      logData[$];
   int              logGid[$];
   int              logCyc[$];
   int              tevtCount = 0;
   int              tevtCyc = -1;

   bit              mBusy = 1'b0;
   int              mGid = 0;
   int              mPtr = 0;
   int              mIdle = 0;
   bit              mTevt = 1'b0;
   int              mCand;
   logic            eValid;
   logic [7:0]      eData;
   logic [NREQ-1:0] eReady;

   uart_tx_arbiter #(
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT),
      .ID_W    (ID_W)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_resetn  (sys_resetn),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .grant_id    (grant_id),
      .timeout_evt (timeout_evt)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
      end
   endtask

   // Reference model: a grant lasts until the grantee's last byte is taken or it stays silent TIMEOUT cycles.
   always @(posedge sys_clk or negedge sys_resetn) begin
      if (!sys_resetn) begin
         mBusy = 1'b0;
         mGid  = 0;
         mPtr  = 0;
         mIdle = 0;
         mTevt = 1'b0;
      end else begin
         mTevt = 1'b0;
         if (!mBusy) begin
            for (int k = 0; k < NREQ; k++) begin
               mCand = (mPtr + k) % NREQ;
               if (!mBusy && req_valid[mCand]) begin
                  mBusy = 1'b1;
                  mGid  = mCand;
                  mIdle = 0;
               end
            end
         end else if (req_valid[mGid]) begin
            mIdle = 0;
            if (tx_ready && req_last[mGid]) begin
               mBusy = 1'b0;
               mPtr  = (mGid + 1) % NREQ;
            end
         end else begin
            mIdle++;
            if (mIdle == TIMEOUT) begin
               mBusy = 1'b0;
               mPtr  = (mGid + 1) % NREQ;
               mTevt = 1'b1;
               mIdle = 0;
            end
         end
      end
   end

   always @(negedge sys_clk) begin
      if (checkEn) begin
         eValid = mBusy ? req_valid[mGid] : 1'b0;
         eData  = mBusy ? req_data[mGid*8 +: 8] : 8'h00;
         eReady = '0;
         if (mBusy && tx_ready) begin
            eReady[mGid] = 1'b1;
         end
         checkOutput("tx_valid", 32'(tx_valid), 32'(eValid));
         checkOutput("tx_data", 32'(tx_data), 32'(eData));
         checkOutput("req_ready", 32'(req_ready), 32'(eReady));
         checkOutput("busy", 32'(busy), 32'(mBusy));
         checkOutput("grant_id", 32'(grant_id), 32'(mGid));
         checkOutput("timeout_evt", 32'(timeout_evt), 32'(mTevt));
      end
   end

   always @(negedge sys_clk) begin
      hsAtNeg = req_valid & req_ready;
      if (sys_resetn && tx_valid && tx_ready) begin
         logData.push_back(tx_data);
         logGid.push_back(int'(grant_id));
         logCyc.push_back(cyc);
      end
      if (timeout_evt) begin
         tevtCount++;
         tevtCyc = cyc;
      end
      cyc++;
   end

   task automatic driveInputs();
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      if (srcQ0.size() > 0) begin
         req_valid[0]   = 1'b1;
         req_data[7:0]  = srcQ0[0][7:0];
         req_last[0]    = srcQ0[0][8];
      end
      if (srcQ1.size() > 0) begin
         req_valid[1]   = 1'b1;
         req_data[15:8] = srcQ1[0][7:0];
         req_last[1]    = srcQ1[0][8];
      end
   endtask

   task automatic applyStimulus(input int reqIdx, input logic [7:0] data, input logic last);
      if (reqIdx == 0) srcQ0.push_back({last, data});
      else             srcQ1.push_back({last, data});
      driveInputs();
   endtask

   task automatic stepCycle();
      @(posedge sys_clk);
      if (hsAtNeg[0]) void'(srcQ0.pop_front());
      if (hsAtNeg[1]) void'(srcQ1.pop_front());
      #1;
      driveInputs();
   endtask

   task automatic runUntilIdle(input string name, input int budget);
      int n = 0;
      while ((srcQ0.size() > 0 || srcQ1.size() > 0 || busy) && n < budget) begin
         stepCycle();
         n++;
      end
      checkOutput({name, "_completed"}, 32'(n < budget), 32'd1);
   endtask

   task automatic waitForLog(input string name, input int count, input int budget);
      int n = 0;
      while (logData.size() < count && n < budget) begin
         stepCycle();
         n++;
      end
      checkOutput({name, "_reached"}, 32'(n < budget), 32'd1);
   endtask

   task automatic checkEntry(input string name, input int i, input logic [7:0] expByte, input int expGid);
      if (i < logData.size()) begin
         checkOutput({name, "_data"}, 32'(logData[i]), 32'(expByte));
         checkOutput({name, "_gid"}, logGid[i], expGid);
      end else begin
         checkOutput({name, "_missing"}, logData.size(), i + 1);
      end
   endtask

   task automatic clearLog();
      logData.delete();
      logGid.delete();
      logCyc.delete();
   endtask

   task automatic applyReset();
      sys_resetn = 1'b0;
      srcQ0.delete();
      srcQ1.delete();
      driveInputs();
      repeat (2) stepCycle();
      sys_resetn = 1'b1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      sys_resetn = 1'b1;
      tx_ready   = 1'b1;
      driveInputs();
      #2;
      sys_resetn = 1'b0;
      checkEn    = 1'b1;
      repeat (3) stepCycle();
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
      checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
      checkOutput("rst_timeout_evt", 32'(timeout_evt), 32'd0);
      sys_resetn = 1'b1;

      // Single requester: three bytes back to back.
      clearLog();
      applyStimulus(0, 8'h41, 1'b0);
      applyStimulus(0, 8'h42, 1'b0);
      applyStimulus(0, 8'h43, 1'b1);
      runUntilIdle("single", 20);
      checkEntry("single0", 0, 8'h41, 0);
      checkEntry("single1", 1, 8'h42, 0);
      checkEntry("single2", 2, 8'h43, 0);
      checkOutput("single_consecutive", logCyc[2] - logCyc[0], 2);

      // Pointer now favours requester 1.
      clearLog();
      applyStimulus(0, 8'h50, 1'b1);
      applyStimulus(1, 8'h60, 1'b1);
      runUntilIdle("rotate", 20);
      checkEntry("rotate0", 0, 8'h60, 1);
      checkEntry("rotate1", 1, 8'h50, 0);

      // Contention straight after reset: requester 0 first, no interleave, two-cycle gap.
      applyReset();
      clearLog();
      applyStimulus(0, 8'h10, 1'b0);
      applyStimulus(0, 8'h11, 1'b1);
      applyStimulus(1, 8'h20, 1'b0);
      applyStimulus(1, 8'h21, 1'b1);
      runUntilIdle("contend", 30);
      checkEntry("contend0", 0, 8'h10, 0);
      checkEntry("contend1", 1, 8'h11, 0);
      checkEntry("contend2", 2, 8'h20, 1);
      checkEntry("contend3", 3, 8'h21, 1);
      checkOutput("contend_gap", logCyc[2] - logCyc[1], 2);

      // Backpressure longer than TIMEOUT must not release the grant.
      clearLog();
      applyStimulus(0, 8'h31, 1'b0);
      applyStimulus(0, 8'h32, 1'b0);
      applyStimulus(0, 8'h33, 1'b1);
      waitForLog("bp_first", 1, 10);
      tx_ready = 1'b0;
      repeat (5) begin
         @(negedge sys_clk);
         checkOutput("bp_tx_valid", 32'(tx_valid), 32'd1);
         checkOutput("bp_tx_data", 32'(tx_data), 32'h32);
         checkOutput("bp_req_ready0", 32'(req_ready[0]), 32'd0);
         checkOutput("bp_busy", 32'(busy), 32'd1);
         stepCycle();
      end
      tx_ready = 1'b1;
      runUntilIdle("bp", 20);
      checkEntry("bp0", 0, 8'h31, 0);
      checkEntry("bp1", 1, 8'h32, 0);
      checkEntry("bp2", 2, 8'h33, 0);
      checkOutput("bp_no_timeout", tevtCount, 0);

      // Stalled grant: four silent cycles after 0x55 force release, then requester 1 goes.
      clearLog();
      applyStimulus(0, 8'h55, 1'b0);
      waitForLog("to_first", 1, 10);
      applyStimulus(1, 8'h66, 1'b1);
      runUntilIdle("timeout", 40);
      checkEntry("timeout0", 0, 8'h55, 0);
      checkEntry("timeout1", 1, 8'h66, 1);
      checkOutput("timeout_pulses", tevtCount, 1);
      checkOutput("timeout_evt_cycle", tevtCyc - logCyc[0], 5);
      checkOutput("timeout_next_grant", logCyc[1] - logCyc[0], 6);

      // Fairness: alternating grants over eight one-byte packets.
      clearLog();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 8'(8'h70 + i), 1'b1);
         applyStimulus(1, 8'(8'h80 + i), 1'b1);
      end
      runUntilIdle("fair", 60);
      for (int i = 0; i < 8; i++) begin
         checkEntry("fair", i, (i % 2 == 0) ? 8'(8'h70 + i / 2) : 8'(8'h80 + i / 2), i % 2);
      end

      // Reset in the middle of requester 1's packet.
      clearLog();
      applyStimulus(1, 8'hA0, 1'b0);
      applyStimulus(1, 8'hA1, 1'b0);
      applyStimulus(1, 8'hA2, 1'b0);
      applyStimulus(1, 8'hA3, 1'b1);
      waitForLog("midrst_bytes", 2, 10);
      checkOutput("midrst_pre_gid", 32'(grant_id), 32'd1);
      sys_resetn = 1'b0;
      #1;
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_tx_valid", 32'(tx_valid), 32'd0);
      checkOutput("midrst_tx_data", 32'(tx_data), 32'd0);
      checkOutput("midrst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("midrst_grant_id", 32'(grant_id), 32'd0);
      srcQ0.delete();
      srcQ1.delete();
      driveInputs();
      repeat (2) stepCycle();
      clearLog();
      applyStimulus(0, 8'hB0, 1'b1);
      applyStimulus(1, 8'hB1, 1'b1);
      sys_resetn = 1'b1;
      runUntilIdle("postrst", 20);
      checkEntry("postrst0", 0, 8'hB0, 0);
      checkEntry("postrst1", 1, 8'hB1, 1);

      repeat (2) stepCycle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
